// File: rtl/slave_memory_master.sv
// -----------------------------------------------------------------------------
// slave_memory_master
//
// Bus initiator for the memory slave. Takes one byte/halfword/word read or
// write request at a time from a client, checks its alignment, runs a single
// transaction on the slave's unidirectional bus while watching the slave's
// Ready with a timeout, and answers with a one-cycle response strobe.
//
// Ports
//   Clk, Rst       clock (rising edge) and synchronous active-high reset
//   ReqValid/ReqReady, ReqWr, ReqSize, ReqAddr, ReqData
//                  client request handshake and fields
//   RspValid, RspData, RspErr
//                  one-cycle response; RspData is zero-extended read data
//   MAddr, MDataOut, MControl, MEn
//                  bus to the slave (MControl[0] write, [2:1] size)
//   SReady, SDataIn
//                  slave ready and read data
// -----------------------------------------------------------------------------
module slave_memory_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  input  logic        ReqWr,
  input  logic [1:0]  ReqSize,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        ReqReady,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspErr,
  output logic [31:0] MAddr,
  output logic [31:0] MDataOut,
  output logic [8:0]  MControl,
  output logic        MEn,
  input  logic        SReady,
  input  logic [31:0] SDataIn
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Wait-counter value of the last BUS cycle before giving up on the slave.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        men_reg, men_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_data_reg, rsp_data_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [31:0] maddr_reg, maddr_next;
  logic [31:0] mdata_reg, mdata_next;
  logic [8:0]  mcontrol_reg, mcontrol_next;

  logic        accept;
  logic        req_err;
  logic        timeout_hit;
  logic [31:0] wr_lanes;
  logic [31:0] rd_lane;

  assign ReqReady = (state_reg == IDLE) & ~Rst;
  assign accept   = ReqValid & ReqReady;

  // Illegal size, or halfword/word not naturally aligned.
  assign req_err = (ReqSize == 2'b11) ||
                   ((ReqSize == 2'b01) && ReqAddr[0]) ||
                   ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));

  assign timeout_hit = ~SReady && (wait_cnt_reg == TIMEOUT_LAST);

  // Replicate narrow write data so the slave finds it on whichever lane the
  // address selects.
  always_comb begin
    case (ReqSize)
      2'b00:   wr_lanes = {4{ReqData[7:0]}};
      2'b01:   wr_lanes = {2{ReqData[15:0]}};
      default: wr_lanes = ReqData;
    endcase
  end

  // Pick the addressed lane out of the slave's word, zero-extended.
  always_comb begin
    rd_lane = SDataIn;
    case (mcontrol_reg[2:1])
      2'b00: begin
        case (maddr_reg[1:0])
          2'b00:   rd_lane = {24'd0, SDataIn[7:0]};
          2'b01:   rd_lane = {24'd0, SDataIn[15:8]};
          2'b10:   rd_lane = {24'd0, SDataIn[23:16]};
          default: rd_lane = {24'd0, SDataIn[31:24]};
        endcase
      end
      2'b01:   rd_lane = maddr_reg[1] ? {16'd0, SDataIn[31:16]} : {16'd0, SDataIn[15:0]};
      default: rd_lane = SDataIn;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = req_err ? RESP : BUS;
        end
      end
      BUS: begin
        if (SReady || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    men_next       = (state_next == BUS);
    rsp_valid_next = (state_next == RESP);
    rsp_data_next  = 32'd0;
    rsp_err_next   = 1'b0;
    maddr_next     = maddr_reg;
    mdata_next     = mdata_reg;
    mcontrol_next  = mcontrol_reg;
    wait_cnt_next  = 8'd0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            rsp_err_next = 1'b1;
          end else begin
            // Bus fields are loaded once here and then held for all of BUS.
            maddr_next    = ReqAddr;
            mdata_next    = wr_lanes;
            mcontrol_next = {6'd0, ReqSize, ReqWr};
          end
        end
      end
      BUS: begin
        wait_cnt_next = wait_cnt_reg + 8'd1;
        if (SReady) begin
          if (!mcontrol_reg[0]) begin
            rsp_data_next = rd_lane;
          end
        end else if (timeout_hit) begin
          rsp_err_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wait_cnt_reg  <= 8'd0;
      men_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 32'd0;
      rsp_err_reg   <= 1'b0;
      maddr_reg     <= 32'd0;
      mdata_reg     <= 32'd0;
      mcontrol_reg  <= 9'd0;
    end else begin
      wait_cnt_reg  <= wait_cnt_next;
      men_reg       <= men_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      maddr_reg     <= maddr_next;
      mdata_reg     <= mdata_next;
      mcontrol_reg  <= mcontrol_next;
    end
  end

  assign MEn      = men_reg;
  assign RspValid = rsp_valid_reg;
  assign RspData  = rsp_data_reg;
  assign RspErr   = rsp_err_reg;
  assign MAddr    = maddr_reg;
  assign MDataOut = mdata_reg;
  assign MControl = mcontrol_reg;

endmodule

// File: tb/tb_slave_memory_master.sv
// -----------------------------------------------------------------------------
// tb_slave_memory_master
//
// Directed bench for slave_memory_master (TIMEOUT = 4). Each request pushes
// its expected response (data, error, bus-enable cycle count, latency) to a
// scoreboard queue; a negedge monitor plays the slave, checks the bus fields
// while MEn is high and pops/compares on every RspValid.
// -----------------------------------------------------------------------------
module tb_slave_memory_master;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          men_cycles;
    int          latency;
  } rsp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqWr = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic [31:0] ReqAddr = 32'd0;
  logic [31:0] ReqData = 32'd0;
  logic        ReqReady;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspErr;
  logic [31:0] MAddr;
  logic [31:0] MDataOut;
  logic [8:0]  MControl;
  logic        MEn;
  logic        SReady = 1'b0;
  logic [31:0] SDataIn = 32'd0;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  rsp_t sb[$];

  // Slave behaviour and bus expectations for the current transaction
  int          ready_wait = 0;
  logic [31:0] slave_data = 32'd0;
  logic [31:0] exp_addr = 32'd0;
  logic [8:0]  exp_ctrl = 9'd0;
  logic [31:0] exp_dout = 32'd0;
  logic        exp_wr = 1'b0;
  int          accept_cyc = 0;
  int          prev_accept = 0;
  int          men_run = 0;

  slave_memory_master #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqWr(ReqWr), .ReqSize(ReqSize),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqReady(ReqReady),
    .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
    .MAddr(MAddr), .MDataOut(MDataOut), .MControl(MControl), .MEn(MEn),
    .SReady(SReady), .SDataIn(SDataIn)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor and slave model
  always @(negedge Clk) begin
    if (Rst) begin
      men_run = 0;
      SReady  = 1'b0;
    end else begin
      if (MEn) begin
        chk("bus_addr", MAddr, exp_addr);
        chk("bus_ctrl", {23'd0, MControl}, {23'd0, exp_ctrl});
        if (exp_wr) chk("bus_wdata", MDataOut, exp_dout);
        SReady  = (men_run == ready_wait);
        SDataIn = SReady ? slave_data : 32'hA5A5A5A5;
        men_run++;
      end else begin
        // Out-of-BUS Ready and data must be ignored.
        SReady  = 1'b1;
        SDataIn = 32'h5A5A5A5A;
      end
      if (RspValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_data", RspData, e.data);
          chk("rsp_err", {31'd0, RspErr}, {31'd0, e.err});
          chk("men_cycles", men_run, e.men_cycles);
          chk("latency", cyc - accept_cyc + 1, e.latency);
          $display("rsp: data=%h err=%0b men=%0d lat=%0d", RspData, RspErr, men_run,
                   cyc - accept_cyc + 1);
        end
        men_run = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ReqReady && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("req_ready_wait", {31'd0, ReqReady}, 32'd1);
  endtask

  task automatic req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] data, input int rw, input logic [31:0] sdata,
                     input logic [31:0] e_data, input logic e_err, input int e_men,
                     input int e_lat, input logic [8:0] e_ctrl, input logic [31:0] e_dout);
    rsp_t e;
    wait_ready();
    ready_wait = rw;
    slave_data = sdata;
    exp_addr   = addr;
    exp_ctrl   = e_ctrl;
    exp_dout   = e_dout;
    exp_wr     = wr;
    e.data = e_data; e.err = e_err; e.men_cycles = e_men; e.latency = e_lat;
    sb.push_back(e);
    ReqValid = 1'b1; ReqWr = wr; ReqSize = size; ReqAddr = addr; ReqData = data;
    @(posedge Clk); #1;
    prev_accept = accept_cyc;
    accept_cyc  = cyc;
    ReqValid    = 1'b0;
    $display("req: wr=%0b size=%0d addr=%h data=%h", wr, size, addr, data);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_req_ready", {31'd0, ReqReady}, 32'd0);
    chk("rst_men", {31'd0, MEn}, 32'd0);
    chk("rst_rsp_valid", {31'd0, RspValid}, 32'd0);
    chk("rst_maddr", MAddr, 32'd0);
    chk("rst_mctrl", {23'd0, MControl}, 32'd0);
    Rst = 1'b0;
    #1;
    chk("idle_req_ready", {31'd0, ReqReady}, 32'd1);

    // Word write, ready in first BUS cycle
    req(1'b1, 2'b10, 32'h078, 32'hDEADBEEF, 0, 32'h0,
        32'h0, 1'b0, 1, 2, 9'h005, 32'hDEADBEEF);
    // Byte read back-to-back, 3 wait cycles
    req(1'b0, 2'b00, 32'h3F6, 32'h0, 3, 32'h12345678,
        32'h00000034, 1'b0, 4, 5, 9'h000, 32'h0);
    chk("issue_interval", accept_cyc - prev_accept, 32'd3);
    // Halfword write
    req(1'b1, 2'b01, 32'h34E, 32'hB7462120, 0, 32'h0,
        32'h0, 1'b0, 1, 2, 9'h003, 32'h21202120);
    // Halfword read, upper lane, one wait cycle
    req(1'b0, 2'b01, 32'h102, 32'h0, 1, 32'hCAFEF00D,
        32'h0000CAFE, 1'b0, 2, 3, 9'h002, 32'h0);
    // Byte write, lane replication
    req(1'b1, 2'b00, 32'h011, 32'h000000C3, 0, 32'h0,
        32'h0, 1'b0, 1, 2, 9'h001, 32'hC3C3C3C3);
    // Misaligned word read, then illegal size
    req(1'b0, 2'b10, 32'h07E, 32'h0, 0, 32'h0,
        32'h0, 1'b1, 0, 1, 9'h004, 32'h0);
    req(1'b0, 2'b11, 32'h100, 32'h0, 0, 32'h0,
        32'h0, 1'b1, 0, 1, 9'h006, 32'h0);
    // Misaligned halfword write
    req(1'b1, 2'b01, 32'h201, 32'h1234, 0, 32'h0,
        32'h0, 1'b1, 0, 1, 9'h003, 32'h0);
    // Timeout with slave never ready
    req(1'b0, 2'b10, 32'h200, 32'h0, -1, 32'hFFFFFFFF,
        32'h0, 1'b1, 4, 5, 9'h004, 32'h0);
    // Next request after timeout behaves normally
    req(1'b0, 2'b10, 32'h204, 32'h0, 1, 32'h89ABCDEF,
        32'h89ABCDEF, 1'b0, 2, 3, 9'h004, 32'h0);
    drain();

    // Reset in the 2nd BUS cycle; no response must appear
    wait_ready();
    ready_wait = -1;
    exp_addr = 32'h300; exp_ctrl = 9'h004; exp_wr = 1'b0;
    ReqValid = 1'b1; ReqWr = 1'b0; ReqSize = 2'b10; ReqAddr = 32'h300; ReqData = 32'h0;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    chk("rst_test_men_c1", {31'd0, MEn}, 32'd1);
    @(posedge Clk); #1;
    chk("rst_test_men_c2", {31'd0, MEn}, 32'd1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("midrst_men", {31'd0, MEn}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, RspValid}, 32'd0);
    chk("midrst_maddr", MAddr, 32'd0);
    chk("midrst_mdout", MDataOut, 32'd0);
    chk("midrst_mctrl", {23'd0, MControl}, 32'd0);
    chk("midrst_req_ready", {31'd0, ReqReady}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, ReqReady}, 32'd1);
    repeat (4) @(posedge Clk);
    #1;
    chk("post_rst_men", {31'd0, MEn}, 32'd0);

    // Recovery after reset
    req(1'b0, 2'b00, 32'h007, 32'h0, 0, 32'hAB000000,
        32'h000000AB, 1'b0, 1, 2, 9'h000, 32'h0);
    drain();
    repeat (3) @(posedge Clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_memory_master.md
# slave_memory_master

Bus initiator that drives the memory slave's unidirectional bus: address, write data, control and enable out; ready and read data in. Accepts single read/write requests (byte, halfword, word) from a client and checks alignment. Runs one bus transaction at a time, with a timeout watchdog on the slave's Ready. Returns one response pulse per accepted request. Sits between the processor/testbench request side and the memory slave on the same clock.

## Interface
- TIMEOUT, 16: number of bus cycles to wait for SReady before aborting; legal range 1..255.
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- ReqValid  in  1  client request present.
- ReqWr  in  1  1 = write, 0 = read.
- ReqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- ReqAddr  in  32  byte address.
- ReqData  in  32  write data, right-justified.
- ReqReady  out  1  request accepted on an edge where ReqValid & ReqReady.
- RspValid  out  1  one-cycle response strobe.
- RspData  out  32  read data, right-justified, zero-extended; 0 for writes and errors.
- RspErr  out  1  misaligned, illegal size, or timeout; qualified by RspValid.
- MAddr  out  32  bus address to slave.
- MDataOut  out  32  bus write data, goes to the slave's DataIn.
- MControl  out  9  [0] = write, [2:1] = size, [8:3] = 0.
- MEn  out  1  bus enable.
- SReady  in  1  slave Ready.
- SDataIn  in  32  slave DataOut.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - ReqReady = 1, except while Rst is high, when it is 0.
  - On accept, latch Wr, Size, Addr and Data.
  - Error requests go to RESP with the error flag set. An error request is: size 11; halfword with Addr[0] = 1; or word with Addr[1:0] ≠ 00.
  - All other requests go to BUS.
- BUS:
  - MEn = 1. MAddr, MControl and MDataOut are held stable for every BUS cycle.
  - Write data lanes: byte is replicated to all four lanes ({4{D[7:0]}}); halfword to both halves ({2{D[15:0]}}); word is passed unchanged.
  - SReady is sampled every BUS cycle, including the first.
  - SReady = 1: on a read, extract the lane and zero-extend it. Byte lane = SDataIn[8*A[1:0] +: 8]; halfword lane = SDataIn[16*A[1] +: 16]. Go to RESP with error flag 0.
  - Timeout: an 8-bit wait counter is cleared on entry to BUS. When SReady is 0 in the cycle where counter == TIMEOUT-1, go to RESP with error flag 1.
- RESP:
  - RspValid = 1 for exactly one cycle, with RspData and RspErr valid; MEn = 0.
  - Next state is always IDLE. There is no response backpressure.
- At most one transaction is outstanding; ReqReady = 0 in BUS and RESP.
- MAddr, MDataOut and MControl keep their last values in IDLE and RESP; MEn is 0 outside BUS.

## Timing
- Reset values: ReqReady 0, RspValid 0, RspData 0, RspErr 0, MEn 0, MAddr 0, MDataOut 0, MControl 0; state IDLE.
- All outputs except ReqReady are registered. ReqReady = (state == IDLE) & ~Rst.
- Accept at edge 0:
  - MEn is high in cycle 1.
  - If SReady = 1 in cycle 1, RspValid is high in cycle 2.
  - Minimum request-to-response time is 2 cycles.
  - Each cycle of SReady low adds one cycle.
- Error requests: RspValid is high in cycle 1 and MEn never rises.
- Timeout: MEn is high for exactly TIMEOUT cycles, and RspValid follows in the next cycle.
- Back-to-back: a new request can be accepted in the cycle after RspValid, so the minimum issue interval is 3 cycles.
- SReady while not in BUS is ignored, and SDataIn is ignored outside the SReady = 1 BUS cycle.
- Rst mid-transaction, in BUS or RESP: at the next edge all outputs take their reset values. MEn drops, no RspValid is produced and the latched request is discarded.
- ReqValid while ReqReady = 0 is ignored; the client must hold it.

## Test plan
- Word write: Addr 0x078, Data 0xDEADBEEF, SReady high in cycle 1.
  - Required: MControl 0x005, MDataOut 0xDEADBEEF, MEn high for 1 cycle.
  - Required: RspValid in cycle 2 with RspErr 0 and RspData 0.
- Byte read: Addr 0x3F6, slave returns 0x12345678 after 3 wait cycles.
  - Required: MControl 0x000, MEn high for 4 cycles, RspData 0x00000034, RspErr 0.
- Halfword write: Addr 0x34E, Data 0xB7462120.
  - Required: MDataOut 0x21202120, MControl 0x003.
- Misaligned and illegal requests: word read at 0x07E, then ReqSize 11.
  - Required: RspValid with RspErr 1 one cycle after accept; MEn never asserted.
- Timeout with TIMEOUT = 4 and SReady held 0.
  - Required: MEn high exactly 4 cycles, then RspValid with RspErr 1 and RspData 0; the next request is accepted normally.
- Reset in the 2nd BUS cycle.
  - Required: all outputs 0 at the next edge, no RspValid.
  - Required: ReqReady returns to 1 in the first cycle after Rst deasserts.
